// File: rtl/adder4_seq_ctrl.sv
// adder4_seq_ctrl: multi-precision add sequencer around an external 4-bit
// ripple adder slice. The operands are fed to the slice one nibble per cycle,
// least significant nibble first. The carry between nibbles is held in a register.
//
// Parameters:
//   NIBBLES  number of 4-bit nibbles per operand (1..16); W = 4*NIBBLES
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start              request strobe; accepted only when idle
//   a, b, ci           operands and carry-in; sampled on accept
//   sub                (ADDER4_SEQ_SUB_EN only) subtract A - B; sampled on accept
//   busy, done         busy through RUN/DONE; done is a one-cycle pulse
//   s, co              registered sum and final carry-out
//   add_a/add_b/add_ci drive to the adder slice (zero outside RUN)
//   add_s/add_co       combinational result from the adder slice
// Optional feature macro: ADDER4_SEQ_SUB_EN (adds the sub port).
module adder4_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
`ifdef ADDER4_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_ci,
  input  logic [3:0]             add_s,
  input  logic                   add_co
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       a_q, b_q, s_q;
  logic               carry_q, co_q;
  logic               busy_q, done_q;
  logic               sub_q;
  logic               last_c;
  logic               sub_in_c;
  logic [3:0]         nib_a_c, nib_b_c;

`ifdef ADDER4_SEQ_SUB_EN
  assign sub_in_c = sub;
`else
  assign sub_in_c = 1'b0;
`endif

  assign last_c = (idx_q == IDX_W'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs, registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  // Operand capture, per-nibble sum write-back and carry chaining
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            // Subtraction is A + ~B + 1, so the initial carry is forced high
            carry_q <= sub_in_c ? 1'b1 : ci;
            sub_q   <= sub_in_c;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) s_q[4*i +: 4] <= add_s;
          end
          carry_q <= add_co;
          if (last_c) co_q  <= add_co;
          else        idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Nibble select of the captured operands
  always_comb begin
    nib_a_c = 4'h0;
    nib_b_c = 4'h0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a_c = a_q[4*i +: 4];
        nib_b_c = b_q[4*i +: 4];
      end
    end
  end

  // Slice drive: active only in RUN, zero otherwise
  always_comb begin
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = nib_a_c;
      add_b  = sub_q ? ~nib_b_c : nib_b_c;
      add_ci = carry_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: doc/adder4_seq_ctrl.md
Name: adder4_seq_ctrl

Overview:
Multi-precision add sequencer built around the shared 4-bit ripple adder slice (adder4). It adds two operands of 4*NIBBLES bits by feeding the slice one nibble per cycle, least significant first, and registers the carry between nibbles. The slice sits outside this block: the controller drives its a/b/ci inputs and captures its s/co outputs. Requesters use a start/busy/done handshake.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
start  input  1  request strobe; accepted only in IDLE.
a  input  W  operand A; sampled when start is accepted.
b  input  W  operand B; sampled when start is accepted.
ci  input  1  carry-in to nibble 0; sampled when start is accepted.
busy  output  1  high while the state is RUN or DONE.
done  output  1  one-cycle pulse in the DONE state.
s  output  W  registered sum.
co  output  1  registered final carry-out.
add_a  output  4  nibble of A presented to the adder slice.
add_b  output  4  nibble of B presented to the adder slice.
add_ci  output  1  carry presented to the adder slice.
add_s  input  4  sum returned by the adder slice (combinational).
add_co  input  1  carry returned by the adder slice (combinational).

Behaviour:
- Reset: state=IDLE, idx=0, carry register=0, operand registers=0, s=0, co=0, busy=0, done=0. A reset in any state, including mid-RUN, aborts the operation and discards partial results.
- States:
  - IDLE: if start=1, latch a, b and ci (into the carry register), set idx=0, go to RUN. Otherwise hold.
  - RUN: drive add_a=A[4*idx+3:4*idx], add_b=B[4*idx+3:4*idx], add_ci=carry register. At the clock edge, write s[4*idx+3:4*idx] from add_s and the carry register from add_co. If idx=NIBBLES-1, copy add_co to co and go to DONE. Otherwise idx=idx+1.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Adder slice drive in IDLE and DONE: add_a=0, add_b=0, add_ci=0.
- Latency: if start is accepted at edge T, RUN spans cycles T+1 through T+NIBBLES, and done is high in cycle T+NIBBLES+1. For NIBBLES=4, done is high 5 cycles after start.
- s and co hold their values from DONE until the next start is accepted. On accept, s and co are not cleared; nibbles are overwritten as RUN progresses.
- start while busy=1 (RUN or DONE) is ignored; there is no queuing. A new start is accepted one cycle after DONE at the earliest.
- start and reset asserted in the same cycle: reset wins and state=IDLE.
- NIBBLES=1: a single RUN cycle, then DONE.
- idx is wide enough for NIBBLES-1. There is no wrap-around, because RUN exits at NIBBLES-1.
- Arithmetic is unsigned modulo 2^W. co is the carry out of bit W-1.

Optional Feature:
Macro ADDER4_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), sampled when start is accepted. When sub=1, add_b is the bitwise inverse of the B nibble in every RUN cycle, the initial carry register is forced to 1 and ci is ignored, so s = A - B mod 2^W and co=1 means no borrow. When sub=0, behaviour is identical to the add path.
- Undefined: no sub port; add only.

Test Plan:
NIBBLES=4, a=0x1234, b=0x4321, ci=0, start pulse -> done high 5 cycles later, s=0x5555, co=0; busy high for 5 cycles.
a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1; add_ci in RUN cycles is 0,1,1,1 (carry chain through every nibble).
a=0x0000, b=0x0000, ci=1 -> s=0x0001, co=0; then a=0x8000, b=0x8000, ci=0 -> s=0x0000, co=1.
start re-asserted with a=0x1111 in the 2nd RUN cycle of a 0x0101+0x0202 operation -> ignored; s=0x0303, and exactly one done pulse.
reset asserted in the 3rd RUN cycle -> next cycle state=IDLE, busy=0, s=0, co=0, add_a=add_b=0; a following 0x0F0F+0x0101 start gives s=0x1010, co=0.
ADDER4_SEQ_SUB_EN: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, co=0; a=0x0007, b=0x0005, sub=1 -> s=0x0002, co=1.
